dac_wave_gen: RTL and testbench
===============================

# dac_wave_gen

Sample-code generator that sits directly upstream of the DAC7611 serial driver. It produces a stream of 12-bit DAC codes (constant, sawtooth, triangle, square) at a programmable sample rate. Each code is presented on a valid/ready handshake that the serial driver consumes one word per frame. It replaces the fixed, hardwired code in the driver with a live, bounded waveform, and flags samples lost when the driver is still busy.

## Interface
- DATA_W, 12, DAC code width (DAC7611 is 12-bit)
- DIV_W, 16, width of the sample-period counter
- clk_X4  in  1  system clock, the same clock that drives the DAC serial driver; all flops on rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  high = generate; low = return to IDLE
- mode  in  2  00 const, 01 sawtooth, 10 triangle, 11 square; latched on IDLE→RUN
- lo  in  DATA_W  lower bound / constant level; read live at each tick
- hi  in  DATA_W  upper bound; read live
- step  in  DATA_W  increment per sample; read live
- period  in  DIV_W  clk_X4 cycles per sample; 0 treated as 1
- code  out  DATA_W  current sample
- code_valid  out  1  code holds an unconsumed sample
- code_ready  in  1  driver accepts code this cycle
- overrun  out  1  one-cycle pulse: tick arrived while previous sample still unconsumed
- overrun_cnt  out  8  saturating overrun count (see Configuration)

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN.
  - IDLE→RUN when enable=1. On that edge: latch mode; acc=lo; dir=up; code=lo; code_valid=1; load period counter with max(period,1)-1.
  - RUN→IDLE when enable=0. On that edge: code_valid=0, counter cleared, acc=lo. An unaccepted sample is discarded.
- Transfer occurs on any edge with code_valid & code_ready. It clears code_valid unless a tick occurs on the same edge.
- Tick: counter reaches 0 in RUN. The counter reloads max(period,1)-1 and the next value is computed from acc.
  - If code_valid=0, or a transfer happens on the same edge: code=next, code_valid=1.
  - Otherwise the new sample is dropped. code stays unchanged, overrun pulses, and acc still advances (the waveform stays time-accurate).
- Next-value rules use DATA_W+1-bit unsigned arithmetic with no wrap-around:
  - const: next=lo.
  - sawtooth: if acc+step > hi, next=lo; else next=acc+step.
  - triangle up: if acc+step >= hi, next=hi and dir=down; else next=acc+step.
  - triangle down: if acc <= lo+step, next=lo and dir=up; else next=acc-step.
  - square: alternates hi, lo, hi… starting after the initial lo.
- Degenerate inputs:
  - lo > hi: every mode outputs lo.
  - step=0 in sawtooth/triangle: output stays at lo.
  - lo=hi: output is constant lo.
- code is stable whenever code_valid=1 and no transfer has occurred.

## Timing
- Reset values: code=0, code_valid=0, overrun=0, overrun_cnt=0, state=IDLE, acc=0, dir=up.
- Latency: enable sampled high at edge k → code_valid=1 with code=lo after edge k.
- Sample n (n≥0) is produced at edge k+n·max(period,1).
- With code_ready held at 1, code_valid is high for exactly one cycle per sample when period≥2, and continuously high when period≤1.
- overrun asserts for one cycle on the tick edge.
- rst mid-RUN overrides everything and returns all outputs to reset values on that edge. enable is ignored during rst.

## Configuration
- DAC_WAVE_OVERRUN_CNT_EN defined: overrun_cnt increments on each overrun pulse and saturates at 255. It is cleared by rst and on IDLE→RUN.
- Not defined: no counter logic is built; overrun_cnt is tied to 0. The overrun pulse is present in both builds.

## Structure
- Shared package dac_pkg:
  - DAC_DATA_W=12
  - mode constants MODE_CONST, MODE_SAW, MODE_TRI, MODE_SQR
  - state encoding ST_IDLE, ST_RUN
- One sub-module, dac_rate_tick: the period down-counter with load/clear inputs and a tick output. The waveform arithmetic and handshake stay in dac_wave_gen.

## Test plan
- Sawtooth: lo=0, hi=10, step=4, period=3, ready=1 → codes 0,4,8,0,4,8, spaced 3 cycles apart, overrun never asserts.
- Triangle: lo=0, hi=10, step=4, period=1, ready=1 → 0,4,8,10,6,2,0,4; code_valid stays high continuously.
- Square: lo=100, hi=3000, period=2, ready=1 → 100,3000,100,3000.
- Backpressure: sawtooth lo=0, hi=100, step=1, period=2, ready=0 for 10 cycles → code holds 0 and overrun pulses 5 times.
  - With DAC_WAVE_OVERRUN_CNT_EN, overrun_cnt reads 5.
  - ready then rises → 0 is accepted and the next tick delivers 6.
- Degenerate: lo=500, hi=200 in sawtooth → constant 500. period=0 → a tick every cycle.
- Control: rst asserted mid-RUN with code_valid=1 → all outputs 0 next edge. enable dropped while code_valid=1 → code_valid=0 next edge; re-enable restarts at lo.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants for the DAC waveform generator: code width, mode encoding, FSM states.
package dac_pkg;

    localparam int unsigned DAC_DATA_W = 12;

    localparam logic [1:0] MODE_CONST = 2'b00;
    localparam logic [1:0] MODE_SAW   = 2'b01;
    localparam logic [1:0] MODE_TRI   = 2'b10;
    localparam logic [1:0] MODE_SQR   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/dac_wave_gen_if.sv
// Sample handshake between the waveform generator (master) and the DAC serial driver (slave).
interface dac_wave_gen_if
    import dac_pkg::*;
#(
    parameter int unsigned DATA_W = DAC_DATA_W
);
    logic [DATA_W-1:0] code;
    logic              code_valid;
    logic              code_ready;

    modport master (output code, output code_valid, input code_ready);
    modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/dac_rate_tick.sv
// Sample-period down-counter: tick fires when the count is 0 while running, then reloads.
module dac_rate_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q;

    assign tick = run && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (load || tick) begin
            cnt_q <= reload;
        end else if (run) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end
endmodule

// File: rtl/dac_wave_gen.sv
// Waveform code generator (const/saw/triangle/square) feeding the DAC7611 driver.
// Define DAC_WAVE_OVERRUN_CNT_EN to build the saturating overrun counter.
module dac_wave_gen
    import dac_pkg::*;
#(
    parameter int unsigned DATA_W = DAC_DATA_W,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk_X4,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] step,
    input  logic [DIV_W-1:0]  period,
    dac_wave_gen_if.master    code_if,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);
    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] acc_q, acc_d, code_q, code_d, next_val;
    logic              dir_q, dir_d, next_dir;   // dir=1 is up; doubles as square phase
    logic              valid_q, valid_d, overrun_q, overrun_d;
    logic              load, clear, run, tick, transfer;
    logic [DIV_W-1:0]  reload;
    logic [DATA_W:0]   sum, lo_step;

    assign reload   = (period == '0) ? '0 : period - DIV_W'(1);
    assign run      = (state_q == ST_RUN) && enable;
    assign transfer = valid_q && code_if.code_ready;
    assign sum      = {1'b0, acc_q} + {1'b0, step};
    assign lo_step  = {1'b0, lo} + {1'b0, step};

    dac_rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
        .clk    (clk_X4),
        .rst    (rst),
        .load   (load),
        .clear  (clear),
        .run    (run),
        .reload (reload),
        .tick   (tick)
    );

    always_comb begin
        next_val = lo;
        next_dir = dir_q;
        if (lo <= hi) begin
            unique case (mode_q)
                MODE_SAW: begin
                    if (step != '0 && sum <= {1'b0, hi}) next_val = sum[DATA_W-1:0];
                end
                MODE_TRI: begin
                    if (step == '0) begin
                        next_dir = 1'b1;
                    end else if (dir_q) begin
                        if (sum >= {1'b0, hi}) begin
                            next_val = hi;
                            next_dir = 1'b0;
                        end else begin
                            next_val = sum[DATA_W-1:0];
                        end
                    end else if ({1'b0, acc_q} <= lo_step) begin
                        next_dir = 1'b1;
                    end else begin
                        next_val = acc_q - step;
                    end
                end
                MODE_SQR: begin
                    next_val = dir_q ? hi : lo;
                    next_dir = ~dir_q;
                end
                default: next_val = lo;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        dir_d     = dir_q;
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    acc_d   = lo;
                    dir_d   = 1'b1;
                    code_d  = lo;
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    acc_d   = lo;
                    clear   = 1'b1;
                end else begin
                    if (transfer) valid_d = 1'b0;
                    if (tick) begin
                        // acc advances even when the sample is dropped, keeping the wave on time
                        acc_d = next_val;
                        dir_d = next_dir;
                        if (!valid_q || transfer) begin
                            code_d  = next_val;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_X4) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_CONST;
            acc_q     <= '0;
            dir_q     <= 1'b1;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            dir_q     <= dir_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign code_if.code       = code_q;
    assign code_if.code_valid = valid_q;
    assign overrun            = overrun_q;

`ifdef DAC_WAVE_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    always_ff @(posedge clk_X4) begin
        if (rst || (state_q == ST_IDLE && enable)) begin
            ovr_cnt_q <= '0;
        end else if (overrun_d && ovr_cnt_q != 8'hff) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`else
    assign overrun_cnt = '0;
`endif
endmodule

// File: tb/tb_dac_wave_gen.sv
// Self-checking bench for dac_wave_gen: fixed waveform table, random trials vs. a sequence model,
// and hand-written backpressure / reset / enable sequences.
module tb_dac_wave_gen;
    import dac_pkg::*;

    logic        clk_X4 = 1'b0;
    logic        rst, enable;
    logic [1:0]  mode;
    logic [11:0] lo, hi, step;
    logic [15:0] period;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    dac_wave_gen_if #(.DATA_W(12)) cif ();

    dac_wave_gen #(.DATA_W(12), .DIV_W(16)) dut (
        .clk_X4      (clk_X4),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .lo          (lo),
        .hi          (hi),
        .step        (step),
        .period      (period),
        .code_if     (cif),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk_X4 = ~clk_X4;

    typedef struct {
        string name;
        int    md;
        int    lo;
        int    hi;
        int    st;
        int    per;
        int    n;
        int    exp[8];
    } vec_t;

    task automatic tick_clk();
        @(posedge clk_X4);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Sample n of the waveform, from the closed-form shape of each mode.
    function automatic int model_sample(int md, int l, int h, int s, int n);
        int cyc[$];
        int m;
        if (md == 0 || l > h) return l;
        if (md == 3) return (n % 2 == 1) ? h : l;
        if (s == 0 || l == h) return l;
        if (md == 1) begin
            m = (h - l) / s + 1;
            return l + (n % m) * s;
        end
        for (int v = l; v < h; v += s) cyc.push_back(v);
        cyc.push_back(h);
        for (int v = h - s; v > l; v -= s) cyc.push_back(v);
        return cyc[n % cyc.size()];
    endfunction

    // Runs one waveform with ready=1 and compares code/valid/overrun every cycle against exp_q.
    task automatic run_wave(input string nm, input int md, input int l, input int h,
                            input int s, input int per);
        int p;
        p = (per == 0) ? 1 : per;
        enable = 1'b0;
        tick_clk();
        tick_clk();
        mode = md[1:0];
        lo = l[11:0];
        hi = h[11:0];
        step = s[11:0];
        period = per[15:0];
        cif.code_ready = 1'b1;
        enable = 1'b1;
        for (int t = 0; t < exp_q.size() * p; t++) begin
            tick_clk();
            if (t % p == 0) begin
                chk({nm, " valid"}, {31'd0, cif.code_valid}, 1);
                chk({nm, " code"}, {20'd0, cif.code}, exp_q[t / p]);
            end else begin
                chk({nm, " gap valid"}, {31'd0, cif.code_valid}, 0);
            end
            chk({nm, " overrun"}, {31'd0, overrun}, 0);
        end
        enable = 1'b0;
        tick_clk();
        chk({nm, " disable valid"}, {31'd0, cif.code_valid}, 0);
    endtask

    vec_t vecs[6];
    int   ov_seen;

    initial begin
        vecs[0] = '{"saw", 1, 0, 10, 4, 3, 6, '{0, 4, 8, 0, 4, 8, 0, 0}};
        vecs[1] = '{"tri", 2, 0, 10, 4, 1, 8, '{0, 4, 8, 10, 6, 2, 0, 4}};
        vecs[2] = '{"sqr", 3, 100, 3000, 0, 2, 4, '{100, 3000, 100, 3000, 0, 0, 0, 0}};
        vecs[3] = '{"lo_gt_hi", 1, 500, 200, 7, 2, 4, '{500, 500, 500, 500, 0, 0, 0, 0}};
        vecs[4] = '{"period0", 1, 0, 10, 1, 0, 5, '{0, 1, 2, 3, 4, 0, 0, 0}};
        vecs[5] = '{"const", 0, 42, 900, 5, 2, 3, '{42, 42, 42, 0, 0, 0, 0, 0}};

        rst = 1'b1;
        enable = 1'b1;
        mode = MODE_SAW;
        lo = 12'd9;
        hi = 12'd100;
        step = 12'd1;
        period = 16'd1;
        cif.code_ready = 1'b0;
        tick_clk();
        tick_clk();
        chk("reset valid", {31'd0, cif.code_valid}, 0);
        chk("reset code", {20'd0, cif.code}, 0);
        chk("reset overrun", {31'd0, overrun}, 0);
        chk("reset overrun_cnt", {24'd0, overrun_cnt}, 0);
        enable = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            exp_q.delete();
            for (int n = 0; n < vecs[i].n; n++) exp_q.push_back(vecs[i].exp[n]);
            run_wave(vecs[i].name, vecs[i].md, vecs[i].lo, vecs[i].hi, vecs[i].st, vecs[i].per);
        end

        for (int r = 0; r < 20; r++) begin
            int md, l, h, s, per;
            md  = int'($urandom_range(0, 3));
            l   = int'($urandom_range(0, 4095));
            h   = int'($urandom_range(0, 4095));
            s   = int'($urandom_range(0, 1500));
            per = int'($urandom_range(0, 4));
            exp_q.delete();
            for (int n = 0; n < 8; n++) exp_q.push_back(model_sample(md, l, h, s, n));
            run_wave("rand", md, l, h, s, per);
        end

        // Backpressure: five ticks land while sample 0 is still held.
        enable = 1'b0;
        tick_clk();
        mode = MODE_SAW;
        lo = 12'd0;
        hi = 12'd100;
        step = 12'd1;
        period = 16'd2;
        cif.code_ready = 1'b0;
        enable = 1'b1;
        tick_clk();
        chk("bp first code", {20'd0, cif.code}, 0);
        ov_seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick_clk();
            chk("bp hold code", {20'd0, cif.code}, 0);
            chk("bp hold valid", {31'd0, cif.code_valid}, 1);
            ov_seen += int'(overrun);
        end
        chk("bp overrun pulses", ov_seen, 5);
`ifdef DAC_WAVE_OVERRUN_CNT_EN
        chk("bp overrun_cnt", {24'd0, overrun_cnt}, 5);
`else
        chk("bp overrun_cnt", {24'd0, overrun_cnt}, 0);
`endif
        cif.code_ready = 1'b1;
        tick_clk();
        chk("bp accept valid", {31'd0, cif.code_valid}, 0);
        tick_clk();
        chk("bp resume valid", {31'd0, cif.code_valid}, 1);
        chk("bp resume code", {20'd0, cif.code}, 6);
        chk("bp resume overrun", {31'd0, overrun}, 0);

        // Enable drop discards the held sample; re-enable restarts at lo.
        cif.code_ready = 1'b0;
        enable = 1'b0;
        tick_clk();
        chk("drop valid", {31'd0, cif.code_valid}, 0);
        lo = 12'd7;
        enable = 1'b1;
        tick_clk();
        chk("reen valid", {31'd0, cif.code_valid}, 1);
        chk("reen code", {20'd0, cif.code}, 7);

        // Reset mid-run with a live sample.
        tick_clk();
        tick_clk();
        rst = 1'b1;
        tick_clk();
        chk("midrst valid", {31'd0, cif.code_valid}, 0);
        chk("midrst code", {20'd0, cif.code}, 0);
        chk("midrst overrun", {31'd0, overrun}, 0);
        chk("midrst overrun_cnt", {24'd0, overrun_cnt}, 0);
        rst = 1'b0;
        enable = 1'b0;
        tick_clk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
